conv2d_stream: RTL

- Parametrised streaming 2D convolver; successor to the fixed 5x5/28x28 convolver.
- Consumes a raster-order pixel stream through a valid/ready handshake and buffers K-1 image rows internally.
- Emits one fixed-point result per valid window position, with configurable stride, optional ReLU and saturation.
- Sits between the pixel source and the pooling/activation stage of each CNN layer; one instance per output channel.

---
 rtl/conv2d_stream_if.sv | 26 ++
 rtl/conv2d_stream.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/conv2d_stream_if.sv
// rtl/conv2d_stream_if.sv - pixel, weight-load and result handshake bundle for conv2d_stream
interface conv2d_stream_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int KERNEL_SIZE = 5
);
    logic                                       write;
    logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] weights_matrix;
    logic [DATA_WIDTH-1:0]                      bias;
    logic                                       pixel_valid;
    logic [DATA_WIDTH-1:0]                      pixel_in;
    logic                                       pixel_ready;
    logic                                       out_valid;
    logic                                       out_ready;
    logic [DATA_WIDTH-1:0]                      result;
    logic                                       frame_done;

    modport master (
        output write, weights_matrix, bias, pixel_valid, pixel_in, out_ready,
        input  pixel_ready, out_valid, result, frame_done
    );

    modport slave (
        input  write, weights_matrix, bias, pixel_valid, pixel_in, out_ready,
        output pixel_ready, out_valid, result, frame_done
    );
endinterface

// File: rtl/conv2d_stream.sv
// rtl/conv2d_stream.sv - streaming KxK fixed-point convolver with line buffers, stride, saturation and ReLU
module conv2d_stream #(
    parameter int DATA_WIDTH  = 16,
    parameter int FRAC_BIT    = 8,
    parameter int KERNEL_SIZE = 5,
    parameter int IMAGE_SIZE  = 28,
    parameter int STRIDE      = 1,
    parameter int RELU_EN     = 1
) (
    input  logic             clk,
    input  logic             reset,
    conv2d_stream_if.slave   bus
);
    localparam int DW    = DATA_WIDTH;
    localparam int K     = KERNEL_SIZE;
    localparam int N     = IMAGE_SIZE;
    localparam int CW    = (N > 1) ? $clog2(N) : 1;
    localparam int ACC_W = 2*DW + $clog2(K*K + 1);

    logic [CW-1:0]       r_q, r_d, c_q, c_d;
    logic [K*K*DW-1:0]   w_q, w_d;
    logic [DW-1:0]       bias_q, bias_d;
    logic [DW-1:0]       result_q, result_d;
    logic                out_valid_q, out_valid_d;
    logic                frame_done_q, frame_done_d;

    // lb_q[0] holds the oldest buffered row, lb_q[K-2] the row just above the current one
    logic [DW-1:0]       lb_q [K-1][N];
    logic [DW-1:0]       lb_d [K-1][N];
    // win_q holds the K-1 most recent columns of the current window, oldest at index 0
    logic [DW-1:0]       win_q [K][K-1];
    logic [DW-1:0]       win_d [K][K-1];
    logic [DW-1:0]       col [K];
    logic [DW-1:0]       wnd [K][K];

    logic                pixel_ready, accept, idle, last_col, last_row;
    logic                row_hit, col_hit, win_done;
    logic signed [2*DW-1:0]  px_ext, wt_ext, prod;
    logic signed [ACC_W-1:0] acc, shifted;
    logic [ACC_W-DW:0]   upper;
    logic [DW-1:0]       sat, conv_out;

    // A new pixel is refused only while a result sits unconsumed in the output register
    assign pixel_ready = !(out_valid_q && !bus.out_ready);
    assign accept      = bus.pixel_valid && pixel_ready;
    assign last_col    = (c_q == CW'(N-1));
    assign last_row    = (r_q == CW'(N-1));
    assign idle        = (r_q == '0) && (c_q == '0) && !out_valid_q;
    assign row_hit     = (int'(r_q) >= K-1) && (((int'(r_q) - (K-1)) % STRIDE) == 0);
    assign col_hit     = (int'(c_q) >= K-1) && (((int'(c_q) - (K-1)) % STRIDE) == 0);
    assign win_done    = accept && row_hit && col_hit;

    assign bus.pixel_ready = pixel_ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.result      = result_q;
    assign bus.frame_done  = frame_done_q;

    // Assemble the full window: buffered columns plus the column completed by the incoming pixel
    always_comb begin
        for (int i = 0; i < K-1; i++) col[i] = lb_q[i][c_q];
        col[K-1] = bus.pixel_in;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K-1; j++) wnd[i][j] = win_q[i][j];
            wnd[i][K-1] = col[i];
        end
    end

    // Full-precision multiply-accumulate, bias, floor shift, saturation and optional rectification
    always_comb begin
        acc    = '0;
        px_ext = '0;
        wt_ext = '0;
        prod   = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                px_ext = {{DW{wnd[i][j][DW-1]}}, wnd[i][j]};
                wt_ext = {{DW{w_q[(i*K+j)*DW + DW-1]}}, w_q[(i*K+j)*DW +: DW]};
                prod   = px_ext * wt_ext;
                acc    = acc + {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
            end
        end
        acc     = acc + ({{(ACC_W-DW){bias_q[DW-1]}}, bias_q} << FRAC_BIT);
        shifted = acc >>> FRAC_BIT;
        upper   = shifted[ACC_W-1:DW-1];
        if ((&upper) || !(|upper))
            sat = shifted[DW-1:0];
        else if (shifted[ACC_W-1])
            sat = {1'b1, {(DW-1){1'b0}}};
        else
            sat = {1'b0, {(DW-1){1'b1}}};
        conv_out = ((RELU_EN != 0) && sat[DW-1]) ? '0 : sat;
    end

    // Line buffer and window shift on every accepted pixel
    always_comb begin
        lb_d  = lb_q;
        win_d = win_q;
        if (accept) begin
            for (int i = 0; i < K-1; i++) lb_d[i][c_q] = col[i+1];
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K-2; j++) win_d[i][j] = win_q[i][j+1];
                win_d[i][K-2] = col[i];
            end
        end
    end

    // Raster counters, output register, frame pulse and idle-only coefficient load
    always_comb begin
        c_d          = c_q;
        r_d          = r_q;
        w_d          = w_q;
        bias_d       = bias_q;
        result_d     = result_q;
        out_valid_d  = out_valid_q;
        frame_done_d = accept && last_col && last_row;
        if (accept) begin
            if (last_col) begin
                c_d = '0;
                r_d = last_row ? '0 : r_q + CW'(1);
            end else begin
                c_d = c_q + CW'(1);
            end
        end
        if (win_done) begin
            out_valid_d = 1'b1;
            result_d    = conv_out;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
        if (bus.write && idle) begin
            w_d    = bus.weights_matrix;
            bias_d = bus.bias;
        end
    end

    // Control and coefficient state, cleared by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q          <= '0;
            c_q          <= '0;
            w_q          <= '0;
            bias_q       <= '0;
            result_q     <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            r_q          <= r_d;
            c_q          <= c_d;
            w_q          <= w_d;
            bias_q       <= bias_d;
            result_q     <= result_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Pixel storage needs no reset: every window is fully refilled before it is used
    always_ff @(posedge clk) begin
        lb_q  <= lb_d;
        win_q <= win_d;
    end
endmodule
